mul_div_unit: RTL and testbench

Parametrised HI/LO multiply/divide unit for the EX stage of the mips32 pipeline. It replaces the ALU-internal divider with a self-contained block that has an explicit Start/Busy/Done handshake and signed/unsigned modes. It also provides iterative restoring division over a configurable width, direct HI/LO writes (mthi/mtlo), and a pipeline Flush. The EX stage reads Hi/Lo for mfhi/mflo and stalls on Busy.

---
 rtl/mul_div_unit.sv | 147 ++++++++++++++
 tb/tb_mul_div_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit for the mips32 EX stage: single-cycle MULT/MULTU,
// iterative restoring DIV/DIVU, mthi/mtlo writes. Define MULDIV_MADD_EN for MADD/MSUB.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WrData,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_FIX} stateType;
    stateType state;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] remReg, quoReg, divisorReg, aRaw;
    logic             negQ, negR, divZero;

    logic             opMult, opDiv, divSigned;
    logic [WIDTH-1:0] absA, absB;
    logic [2*WIDTH-1:0] aSext, bSext, aZext, bZext, prodSigned, prodUnsigned;
    logic [WIDTH:0]   shifted, trial;

    assign opMult    = (Op == 3'b000) || (Op == 3'b001);
    assign opDiv     = (Op == 3'b010) || (Op == 3'b011);
    assign divSigned = ~Op[0];

    assign aSext = {{WIDTH{A[WIDTH-1]}}, A};
    assign bSext = {{WIDTH{B[WIDTH-1]}}, B};
    assign aZext = {{WIDTH{1'b0}}, A};
    assign bZext = {{WIDTH{1'b0}}, B};
    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    assign prodSigned   = aSext * bSext;
    assign prodUnsigned = aZext * bZext;

    assign absA = (divSigned && A[WIDTH-1]) ? (-A) : A;
    assign absB = (divSigned && B[WIDTH-1]) ? (-B) : B;

    // quoReg starts as the dividend and shifts out its MSB into the remainder.
    assign shifted = {remReg, quoReg[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisorReg};

`ifdef MULDIV_MADD_EN
    logic               opMadd;
    logic [2*WIDTH-1:0] accSum;
    assign opMadd = (Op == 3'b100) || (Op == 3'b101);
    assign accSum = Op[0] ? ({Hi, Lo} - prodSigned) : ({Hi, Lo} + prodSigned);
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            aRaw       <= '0;
            negQ       <= 1'b0;
            negR       <= 1'b0;
            divZero    <= 1'b0;
            Hi         <= '0;
            Lo         <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (HiWrite) Hi <= WrData;
                    if (LoWrite) Lo <= WrData;
                    if (Start && !Flush) begin
                        if (opMult) begin
                            {Hi, Lo} <= Op[0] ? prodUnsigned : prodSigned;
                            Done     <= 1'b1;
                        end
`ifdef MULDIV_MADD_EN
                        else if (opMadd) begin
                            {Hi, Lo} <= accSum;
                            Done     <= 1'b1;
                        end
`endif
                        else if (opDiv) begin
                            remReg     <= '0;
                            quoReg     <= absA;
                            divisorReg <= absB;
                            aRaw       <= A;
                            negQ       <= divSigned && (A[WIDTH-1] ^ B[WIDTH-1]);
                            negR       <= divSigned && A[WIDTH-1];
                            divZero    <= (B == '0);
                            cnt        <= CNT_INIT;
                            Busy       <= 1'b1;
                            state      <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    if (Flush) begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (trial[WIDTH]) begin
                            remReg <= shifted[WIDTH-1:0];
                            quoReg <= {quoReg[WIDTH-2:0], 1'b0};
                        end else begin
                            remReg <= trial[WIDTH-1:0];
                            quoReg <= {quoReg[WIDTH-2:0], 1'b1};
                        end
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    if (!Flush) begin
                        // Most-negative / -1 falls out naturally: -(2^(W-1)) wraps to itself.
                        if (divZero) begin
                            Lo <= '1;
                            Hi <= aRaw;
                        end else begin
                            Lo <= negQ ? (-quoReg) : quoReg;
                            Hi <= negR ? (-remReg) : remReg;
                        end
                        Done <= 1'b1;
                    end
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against an arithmetic HI/LO model.
module tb_mul_div_unit;
    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] A = '0, B = '0, WrData = '0;
    logic        HiWrite = 1'b0, LoWrite = 1'b0, Flush = 1'b0;
    logic        Busy, Done;
    logic [31:0] Hi, Lo;

    int checks = 0;
    int failures = 0;
    logic [31:0] mHi = '0, mLo = '0;

    mul_div_unit #(.WIDTH(32)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiWrite(HiWrite), .LoWrite(LoWrite), .WrData(WrData), .Flush(Flush),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [63:0] modelMul(input logic [2:0] op, input logic [31:0] a, b,
                                              input logic [63:0] acc);
        logic [63:0] sp = longint'($signed(a)) * longint'($signed(b));
        logic [63:0] up = {32'h0, a} * {32'h0, b};
        case (op)
            3'd0: return sp;
            3'd1: return up;
            3'd4: return acc + sp;
            default: return acc - sp;
        endcase
    endfunction

    function automatic logic [63:0] modelDiv(input logic [2:0] op, input logic [31:0] a, b);
        int q, r;
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (op == 3'd2) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    function automatic logic [31:0] rndVal;
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic doWrite(input logic hw, lw, input logic [31:0] wd);
        HiWrite = hw; LoWrite = lw; WrData = wd;
        tick;
        HiWrite = 1'b0; LoWrite = 1'b0;
        if (hw) mHi = wd;
        if (lw) mLo = wd;
        chk("write", {Hi, Lo}, {mHi, mLo});
    endtask

    // Single-cycle ops and reserved ops; writes in the same cycle lose to a product.
    task automatic doSingle(input logic [2:0] op, input logic [31:0] a, b,
                            input logic hw, lw, input logic [31:0] wd);
        logic isMul;
        isMul = (op <= 3'd1);
`ifdef MULDIV_MADD_EN
        isMul = isMul || (op == 3'd4) || (op == 3'd5);
`endif
        Start = 1'b1; Op = op; A = a; B = b; HiWrite = hw; LoWrite = lw; WrData = wd;
        tick;
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
        if (isMul) {mHi, mLo} = modelMul(op, a, b, {mHi, mLo});
        else begin
            if (hw) mHi = wd;
            if (lw) mLo = wd;
        end
        chk("single_done", Done, isMul);
        chk("single_busy", Busy, 1'b0);
        chk("single_hilo", {Hi, Lo}, {mHi, mLo});
        tick;
        chk("single_done_clr", Done, 1'b0);
    endtask

    task automatic doDiv(input logic [2:0] op, input logic [31:0] a, b,
                         input logic hw, lw, input logic [31:0] wd, input logic junk);
        int n = 0;
        logic held = 1'b1, doneSeen = 1'b0;
        Start = 1'b1; Op = op; A = a; B = b; HiWrite = hw; LoWrite = lw; WrData = wd;
        tick;
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
        if (hw) mHi = wd;
        if (lw) mLo = wd;
        while (Busy && n < 200) begin
            n++;
            if ({Hi, Lo} !== {mHi, mLo}) held = 1'b0;
            if (Done) doneSeen = 1'b1;
            if (junk) begin
                Start = 1'($urandom_range(0, 1)); Op = 3'($urandom_range(0, 7));
                A = $urandom; B = $urandom;
                HiWrite = 1'($urandom_range(0, 1)); LoWrite = 1'($urandom_range(0, 1));
                WrData = $urandom;
            end
            tick;
        end
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
        {mHi, mLo} = modelDiv(op, a, b);
        chk("div_latency", n, 33);
        chk("div_hold", held, 1'b1);
        chk("div_early_done", doneSeen, 1'b0);
        chk("div_done", Done, 1'b1);
        chk("div_hilo", {Hi, Lo}, {mHi, mLo});
        tick;
        chk("div_done_clr", Done, 1'b0);
    endtask

    initial begin
        logic doneSeen;
        #1;
        chk("rst_hilo", {Hi, Lo}, 64'h0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        #10 Reset = 1'b1;
        tick;

        doSingle(3'd0, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0);
        chk("tp_mult", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFF);
        doSingle(3'd1, 32'hFFFFFFFF, 32'h2, 1'b1, 1'b1, 32'h1234);
        chk("tp_multu", {Hi, Lo}, 64'h00000001_FFFFFFFE);

        doDiv(3'd2, 32'd11, 32'd3, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("tp_div_11_3", {Hi, Lo}, {32'd2, 32'd3});
        doDiv(3'd2, 32'd6, 32'd3, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("tp_div_6_3", {Hi, Lo}, {32'd0, 32'd2});
        doDiv(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("tp_div_neg", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFD);
        doDiv(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("tp_divu", {Hi, Lo}, 64'h00000001_7FFFFFFC);
        doDiv(3'd3, 32'd5, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("tp_divz", {Hi, Lo}, 64'h00000005_FFFFFFFF);
        doDiv(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("tp_div_ovf", {Hi, Lo}, 64'h00000000_80000000);
        // Write alongside a DIV start is visible while busy, then overwritten.
        doDiv(3'd2, 32'd100, 32'd7, 1'b1, 1'b1, 32'hABCD, 1'b0);
        // Starts and writes while busy must be ignored.
        doDiv(3'd2, 32'd100, 32'd7, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("tp_busy_ignore", {Hi, Lo}, {32'd2, 32'd14});

        // Flush mid-divide.
        doWrite(1'b1, 1'b0, 32'd7);
        doWrite(1'b0, 1'b1, 32'd9);
        Start = 1'b1; Op = 3'd2; A = 32'd10; B = 32'd3;
        tick;
        Start = 1'b0;
        repeat (8) tick;
        chk("flush_pre_busy", Busy, 1'b1);
        Flush = 1'b1;
        tick;
        Flush = 1'b0;
        chk("flush_busy", Busy, 1'b0);
        doneSeen = 1'b0;
        repeat (40) begin
            if (Done || Busy) doneSeen = 1'b1;
            tick;
        end
        chk("flush_no_done", doneSeen, 1'b0);
        chk("flush_hilo", {Hi, Lo}, {32'd7, 32'd9});

        // Reset mid-divide.
        doWrite(1'b1, 1'b1, 32'd7);
        Start = 1'b1; Op = 3'd2; A = 32'd10; B = 32'd3;
        tick;
        Start = 1'b0;
        repeat (9) tick;
        Reset = 1'b0;
        #1;
        mHi = '0; mLo = '0;
        chk("rst_mid_hilo", {Hi, Lo}, 64'h0);
        chk("rst_mid_busy", Busy, 1'b0);
        #2 Reset = 1'b1;
        tick;
        chk("rst_mid_done", Done, 1'b0);

        // Flush beats Start in IDLE.
        doWrite(1'b1, 1'b1, 32'd3);
        Flush = 1'b1; Start = 1'b1; Op = 3'd0; A = 32'd5; B = 32'd6;
        tick;
        Flush = 1'b0; Start = 1'b0;
        chk("idle_flush_done", Done, 1'b0);
        chk("idle_flush_hilo", {Hi, Lo}, {mHi, mLo});

        doSingle(3'd6, 32'd3, 32'd4, 1'b0, 1'b0, 32'h0);
        doSingle(3'd7, 32'd3, 32'd4, 1'b1, 1'b0, 32'h55);

        doWrite(1'b1, 1'b0, 32'd0);
        doWrite(1'b0, 1'b1, 32'd5);
        doSingle(3'd4, 32'd3, 32'd4, 1'b0, 1'b0, 32'h0);
`ifdef MULDIV_MADD_EN
        chk("tp_madd", {Hi, Lo}, {32'd0, 32'd17});
        doSingle(3'd5, 32'd2, 32'd10, 1'b0, 1'b0, 32'h0);
        chk("tp_msub", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFD);
`else
        chk("madd_reserved", {Hi, Lo}, {32'd0, 32'd5});
        doSingle(3'd5, 32'd2, 32'd10, 1'b0, 1'b0, 32'h0);
`endif

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: doSingle(3'($urandom_range(0, 1)), rndVal(), rndVal(),
                                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
                3, 4, 5: doDiv(3'($urandom_range(2, 3)), rndVal(), rndVal(),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                               1'($urandom_range(0, 1)));
                6, 7: doSingle(3'($urandom_range(4, 7)), rndVal(), rndVal(),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
                default: doWrite(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
